pcs_tx_code_group_ctrl: RTL and testbench

// Code-group sequencer of the 1000BASE-X PCS transmit path (Clause 36, Fig 36-6 style).

---
 rtl/pcs_tx_code_group_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pcs_tx_code_group_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_code_group_ctrl.sv
// pcs_tx_code_group_ctrl
// Code-group sequencer for the 1000BASE-X PCS transmit path. It sits between
// the ordered-set transmit FSM and the 8b/10b encoder, and expands each
// requested ordered set into one octet plus a K flag per clock.
//
// Ports
//   GTX_CLK           in   code-group clock, one code-group per rising edge
//   mr_main_reset     in   asynchronous reset, active-low
//   tx_o_set[2:0]     in   0 /D/, 1 /I/, 2 /S/, 3 /T/, 4 /R/, 5 /V/, 6 /C/, 7 invalid
//   TXD[7:0]          in   data octet for /D/
//   tx_disparity      in   encoder running disparity, 1 = positive
//   tx_config_reg     in   16-bit config word carried in /C/
//   tx_code_octet     out  octet to the encoder
//   tx_code_is_k      out  1 = octet is a K code
//   tx_even           out  1 = current code-group occupies an even slot
//   TX_OSET_indicate  out  1 = current code-group is the last of its ordered set
//
// State    | meaning (what the next rising edge produces)
// GENERATE | sample a new set; emit its only/first code-group or an /R/ pad
// PAD      | emit K28.5 of the /I/ or /C/ held across the pad
// IDLE_B   | emit second /I/ code-group (D5.6 or D16.2)
// CFG_B    | emit D21.5 (C1) or D2.2 (C2)
// CFG_C    | emit config low octet
// CFG_D    | emit config high octet, set complete
module pcs_tx_code_group_ctrl #(
   parameter bit         EN_ALIGN_PAD  = 1'b1,
   parameter logic [7:0] INVALID_OCTET = 8'hFE
) (
   input  logic        GTX_CLK,
   input  logic        mr_main_reset,
   input  logic [2:0]  tx_o_set,
   input  logic [7:0]  TXD,
   input  logic        tx_disparity,
   input  logic [15:0] tx_config_reg,
   output logic [7:0]  tx_code_octet,
   output logic        tx_code_is_k,
   output logic        tx_even,
   output logic        TX_OSET_indicate
);

   localparam logic [2:0] OS_D = 3'd0;
   localparam logic [2:0] OS_I = 3'd1;
   localparam logic [2:0] OS_S = 3'd2;
   localparam logic [2:0] OS_T = 3'd3;
   localparam logic [2:0] OS_R = 3'd4;
   localparam logic [2:0] OS_V = 3'd5;
   localparam logic [2:0] OS_C = 3'd6;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [7:0] D5_6  = 8'hC5;
   localparam logic [7:0] D16_2 = 8'h50;
   localparam logic [7:0] D21_5 = 8'hB5;
   localparam logic [7:0] D2_2  = 8'h42;

   typedef enum logic [2:0] {
      ST_GENERATE,
      ST_PAD,
      ST_IDLE_B,
      ST_CFG_B,
      ST_CFG_C,
      ST_CFG_D
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  oset_q, oset_d;
   logic        disp_q, disp_d;
   logic [15:0] cfg_q, cfg_d;
   logic        alt_q, alt_d;     // set in progress is C2
   logic        tog_q, tog_d;     // next /C/ set will be C2
   logic [7:0]  octet_q, octet_d;
   logic        k_q, k_d;
   logic        even_q, even_d;
   logic        ind_q, ind_d;

   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state_q <= ST_GENERATE;
         oset_q  <= OS_I;
         disp_q  <= 1'b0;
         cfg_q   <= 16'h0000;
         alt_q   <= 1'b0;
         tog_q   <= 1'b0;
         octet_q <= 8'h00;
         k_q     <= 1'b0;
         even_q  <= 1'b0;
         ind_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         oset_q  <= oset_d;
         disp_q  <= disp_d;
         cfg_q   <= cfg_d;
         alt_q   <= alt_d;
         tog_q   <= tog_d;
         octet_q <= octet_d;
         k_q     <= k_d;
         even_q  <= even_d;
         ind_q   <= ind_d;
      end
   end

   always_comb begin
      state_d = state_q;
      oset_d  = oset_q;
      disp_d  = disp_q;
      cfg_d   = cfg_q;
      alt_d   = alt_q;
      tog_d   = tog_q;
      octet_d = 8'h00;
      k_d     = 1'b0;
      ind_d   = 1'b0;
      even_d  = ~even_q;

      case (state_q)
         ST_GENERATE: begin
            // Only reached when TX_OSET_indicate is high, so this is the
            // sampling edge for a new ordered set.
            oset_d = tx_o_set;
            disp_d = tx_disparity;
            cfg_d  = tx_config_reg;
            if (tx_o_set == OS_C) begin
               alt_d = tog_q;
               tog_d = ~tog_q;
            end else begin
               alt_d = 1'b0;
               tog_d = 1'b0;
            end
            case (tx_o_set)
               OS_D: begin octet_d = TXD;   ind_d = 1'b1; end
               OS_S: begin octet_d = K27_7; k_d = 1'b1; ind_d = 1'b1; end
               OS_T: begin octet_d = K29_7; k_d = 1'b1; ind_d = 1'b1; end
               OS_R: begin octet_d = K23_7; k_d = 1'b1; ind_d = 1'b1; end
               OS_V: begin octet_d = K30_7; k_d = 1'b1; ind_d = 1'b1; end
               OS_I, OS_C: begin
                  k_d = 1'b1;
                  // even_q high means the upcoming slot is odd.
                  if (EN_ALIGN_PAD && even_q) begin
                     octet_d = K23_7;
                     state_d = ST_PAD;
                  end else begin
                     octet_d = K28_5;
                     state_d = (tx_o_set == OS_I) ? ST_IDLE_B : ST_CFG_B;
                  end
               end
               default: begin octet_d = INVALID_OCTET; k_d = 1'b1; ind_d = 1'b1; end
            endcase
         end
         ST_PAD: begin
            octet_d = K28_5;
            k_d     = 1'b1;
            state_d = (oset_q == OS_I) ? ST_IDLE_B : ST_CFG_B;
         end
         ST_IDLE_B: begin
            octet_d = disp_q ? D5_6 : D16_2;
            ind_d   = 1'b1;
            state_d = ST_GENERATE;
         end
         ST_CFG_B: begin
            octet_d = alt_q ? D2_2 : D21_5;
            state_d = ST_CFG_C;
         end
         ST_CFG_C: begin
            octet_d = cfg_q[7:0];
            state_d = ST_CFG_D;
         end
         ST_CFG_D: begin
            octet_d = cfg_q[15:8];
            ind_d   = 1'b1;
            state_d = ST_GENERATE;
         end
         default: begin
            ind_d   = 1'b1;
            state_d = ST_GENERATE;
         end
      endcase
   end

   assign tx_code_octet    = octet_q;
   assign tx_code_is_k     = k_q;
   assign tx_even          = even_q;
   assign TX_OSET_indicate = ind_q;

endmodule

// File: tb/tb_pcs_tx_code_group_ctrl.sv
// Bench for pcs_tx_code_group_ctrl: one instance with alignment padding, one
// without, both driven by the same stimulus and each checked every clock
// against a reference model that expands ordered sets into code-group lists.
module tb_pcs_tx_code_group_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  os;
   logic [7:0]  txd;
   logic        disp;
   logic [15:0] cfg;

   logic [7:0]  oct0, oct1;
   logic        k0, k1, ev0, ev1, ind0, ind1;

   always #5 clk = ~clk;

   pcs_tx_code_group_ctrl #(.EN_ALIGN_PAD(1'b1), .INVALID_OCTET(8'hFE)) dut_pad (
      .GTX_CLK(clk), .mr_main_reset(rst_n), .tx_o_set(os), .TXD(txd),
      .tx_disparity(disp), .tx_config_reg(cfg),
      .tx_code_octet(oct0), .tx_code_is_k(k0), .tx_even(ev0), .TX_OSET_indicate(ind0));

   pcs_tx_code_group_ctrl #(.EN_ALIGN_PAD(1'b0), .INVALID_OCTET(8'hFE)) dut_nopad (
      .GTX_CLK(clk), .mr_main_reset(rst_n), .tx_o_set(os), .TXD(txd),
      .tx_disparity(disp), .tx_config_reg(cfg),
      .tx_code_octet(oct1), .tx_code_is_k(k1), .tx_even(ev1), .TX_OSET_indicate(ind1));

   typedef struct packed {
      logic [7:0] o;
      logic       k;
      logic       ind;
   } cg_t;

   cg_t         q0[$];
   cg_t         q1[$];
   cg_t         tmp_q[$];
   logic        even_m[2];
   logic        tog_m[2];
   logic [10:0] exp_m[2];
   int          n_total = 0;
   int          n_bad   = 0;

   // {octet, k, even, indicate}
   logic [10:0] t1_tbl[4] = '{{8'hBC,1'b1,1'b1,1'b0}, {8'h50,1'b0,1'b0,1'b1},
                              {8'hBC,1'b1,1'b1,1'b0}, {8'h50,1'b0,1'b0,1'b1}};
   // {octet, indicate}
   logic [8:0]  t3_tbl[8] = '{{8'hBC,1'b0}, {8'hB5,1'b0}, {8'hA0,1'b0}, {8'h01,1'b1},
                              {8'hBC,1'b0}, {8'h42,1'b0}, {8'hA0,1'b0}, {8'h01,1'b1}};
   logic [2:0]  t4_os[7]   = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd1};
   logic [7:0]  t4_txd[7]  = '{8'h00, 8'h9A, 8'hB5, 8'h42, 8'h00, 8'h00, 8'h00};
   logic [7:0]  t4_pad[7]  = '{8'hFB, 8'h9A, 8'hB5, 8'h42, 8'hFD, 8'hF7, 8'hBC};
   logic [7:0]  t4_np[7]   = '{8'hFB, 8'h9A, 8'hB5, 8'h42, 8'hFD, 8'hBC, 8'h50};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic cg_t mk(input logic [7:0] o, input logic k, input logic ind);
      cg_t c;
      c.o = o; c.k = k; c.ind = ind;
      return c;
   endfunction

   // Ordered-set expansion into the code-group list the encoder should see.
   task automatic expand(input logic [2:0] s, input logic [7:0] d, input logic dp,
                         input logic [15:0] c, input logic pad, input logic alt);
      tmp_q.delete();
      if (pad && (s == 3'd1 || s == 3'd6)) tmp_q.push_back(mk(8'hF7, 1'b1, 1'b0));
      case (s)
         3'd0: tmp_q.push_back(mk(d, 1'b0, 1'b1));
         3'd1: begin
            tmp_q.push_back(mk(8'hBC, 1'b1, 1'b0));
            tmp_q.push_back(mk(dp ? 8'hC5 : 8'h50, 1'b0, 1'b1));
         end
         3'd2: tmp_q.push_back(mk(8'hFB, 1'b1, 1'b1));
         3'd3: tmp_q.push_back(mk(8'hFD, 1'b1, 1'b1));
         3'd4: tmp_q.push_back(mk(8'hF7, 1'b1, 1'b1));
         3'd5: tmp_q.push_back(mk(8'hFE, 1'b1, 1'b1));
         3'd6: begin
            tmp_q.push_back(mk(8'hBC, 1'b1, 1'b0));
            tmp_q.push_back(mk(alt ? 8'h42 : 8'hB5, 1'b0, 1'b0));
            tmp_q.push_back(mk(c[7:0], 1'b0, 1'b0));
            tmp_q.push_back(mk(c[15:8], 1'b0, 1'b1));
         end
         default: tmp_q.push_back(mk(8'hFE, 1'b1, 1'b1));
      endcase
   endtask

   task automatic step_model(input int m);
      cg_t e;
      int  sz;
      sz = (m == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         expand(os, txd, disp, cfg, (m == 0) && even_m[m], tog_m[m]);
         tog_m[m] = (os == 3'd6) ? ~tog_m[m] : 1'b0;
         foreach (tmp_q[i]) begin
            if (m == 0) q0.push_back(tmp_q[i]);
            else        q1.push_back(tmp_q[i]);
         end
      end
      if (m == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      even_m[m] = ~even_m[m];
      exp_m[m]  = {e.o, e.k, even_m[m], e.ind};
   endtask

   task automatic cycle();
      @(posedge clk);
      step_model(0);
      step_model(1);
      #1;
      check("cg_pad",   {oct0, k0, ev0, ind0}, exp_m[0]);
      check("cg_nopad", {oct1, k1, ev1, ind1}, exp_m[1]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_async_pad",   {oct0, k0, ev0, ind0}, {8'h00, 1'b0, 1'b0, 1'b1});
      check("rst_async_nopad", {oct1, k1, ev1, ind1}, {8'h00, 1'b0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      check("rst_hold", {oct0, k0, ev0, ind0}, {8'h00, 1'b0, 1'b0, 1'b1});
      #2;
      q0.delete();
      q1.delete();
      even_m[0] = 1'b0; even_m[1] = 1'b0;
      tog_m[0]  = 1'b0; tog_m[1]  = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      os = 3'd1; txd = 8'h00; disp = 1'b0; cfg = 16'h0000;
      #2;

      // T1: idle out of reset, negative disparity
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t1_seq", {oct0, k0, ev0, ind0}, t1_tbl[i]);
      end

      // T2: idle with positive disparity, disparity wiggling mid-set
      disp = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         disp = 1'($urandom);
      end

      // T3: /C/ held, C1 then C2
      do_reset();
      os = 3'd6; cfg = 16'h01A0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("t3_pad",   {oct0, ind0}, t3_tbl[i]);
         check("t3_nopad", {oct1, ind1}, t3_tbl[i]);
      end

      // T6: reset during 3rd code-group of C1, restart as C1
      do_reset();
      os = 3'd6; cfg = 16'h01A0;
      for (int i = 0; i < 3; i++) cycle();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("t6_restart", oct0, t3_tbl[i][8:1]);
      end

      // T4: packet framing then idle needing alignment
      do_reset();
      os = 3'd1; disp = 1'b0;
      cycle();
      cycle();
      for (int i = 0; i < 7; i++) begin
         os = t4_os[i]; txd = t4_txd[i];
         cycle();
         check("t4_pad",   oct0, t4_pad[i]);
         check("t4_nopad", oct1, t4_np[i]);
      end
      cycle();

      // T5: invalid encoding, then random traffic with occasional reset
      os = 3'd7;
      cycle();
      check("t5_invalid", {oct0, k0, ind0}, {8'hFE, 1'b1, 1'b1});
      os = 3'd0; txd = 8'h3C;
      cycle();
      check("t5_next", {oct0, k0, ind0}, {8'h3C, 1'b0, 1'b1});

      for (int i = 0; i < 800; i++) begin
         os   = 3'($urandom_range(0, 7));
         txd  = 8'($urandom);
         disp = 1'($urandom);
         cfg  = 16'($urandom);
         if ($urandom_range(0, 199) == 0) do_reset();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
